matrix_axil_regs: RTL and testbench

AXI4-Lite slave register file that answers the bus master driving the MATRIX_IPBLOK_DEF peripheral. It holds four 32-bit software-visible registers for the matrix game logic and accepts write address/data in either order. It drives B and R responses with full VALID/READY handshaking. It also presents the register contents and per-register write pulses to the fabric side.

---
 rtl/matrix_axil_regs.sv | 174 +++++++++++++++++
 tb/tb_matrix_axil_regs.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_axil_regs.sv
// AXI4-Lite slave holding four 32-bit registers for the matrix game logic.
// Define MATRIX_REGS_SLVERR_EN to reject addresses at or above 0x10 with SLVERR.
module matrix_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [4*C_S_AXI_DATA_WIDTH-1:0]   REG_OUT,
    output logic [3:0]                        WR_PULSE
);

    localparam int         DW     = C_S_AXI_DATA_WIDTH;
    localparam int         AW     = C_S_AXI_ADDR_WIDTH;
    localparam int         SW     = DW / 8;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic [DW-1:0] regs [4];

    logic          aw_held;
    logic [AW-1:0] aw_addr_q;
    logic          w_held;
    logic [DW-1:0] w_data_q;
    logic [SW-1:0] w_strb_q;
    logic          bvalid;
    logic [1:0]    bresp;
    logic          rvalid;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic [3:0]    wr_pulse;

    logic          aw_hs;
    logic          w_hs;
    logic          ar_hs;
    logic          wr_commit;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [SW-1:0] wr_strb;
    logic [1:0]    wr_idx;
    logic [1:0]    rd_idx;
    logic          wr_oor;
    logic          rd_oor;
    logic          unused_ok;

    function automatic logic [DW-1:0] byte_merge(input logic [DW-1:0] old_val,
                                                 input logic [DW-1:0] new_val,
                                                 input logic [SW-1:0] strb);
        logic [DW-1:0] res;
        res = old_val;
        for (int k = 0; k < SW; k++) begin
            if (strb[k]) begin
                res[8*k +: 8] = new_val[8*k +: 8];
            end
        end
        return res;
    endfunction

    // READY decode: one write outstanding at most, one read outstanding at most
    assign S_AXI_AWREADY = !aw_held && !bvalid && !ARESET;
    assign S_AXI_WREADY  = !w_held && !bvalid && !ARESET;
    assign S_AXI_ARREADY = !rvalid && !ARESET;

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    // A held half combines with the other half arriving this edge
    assign wr_addr   = aw_held ? aw_addr_q : S_AXI_AWADDR;
    assign wr_data   = w_held ? w_data_q : S_AXI_WDATA;
    assign wr_strb   = w_held ? w_strb_q : S_AXI_WSTRB;
    assign wr_commit = (aw_held || aw_hs) && (w_held || w_hs) && !bvalid;
    assign wr_idx    = wr_addr[3:2];
    assign rd_idx    = S_AXI_ARADDR[3:2];

`ifdef MATRIX_REGS_SLVERR_EN
    assign wr_oor = |wr_addr[AW-1:4];
    assign rd_oor = |S_AXI_ARADDR[AW-1:4];
`else
    assign wr_oor = 1'b0;
    assign rd_oor = 1'b0;
`endif

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_held   <= 1'b0;
            aw_addr_q <= '0;
            w_held    <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else if (wr_commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_held   <= 1'b1;
                aw_addr_q <= S_AXI_AWADDR;
            end
            if (w_hs) begin
                w_held   <= 1'b1;
                w_data_q <= S_AXI_WDATA;
                w_strb_q <= S_AXI_WSTRB;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
            wr_pulse <= '0;
            bvalid   <= 1'b0;
            bresp    <= OKAY;
        end else begin
            wr_pulse <= '0;
            if (wr_commit) begin
                bvalid <= 1'b1;
                bresp  <= wr_oor ? SLVERR : OKAY;
                if (!wr_oor) begin
                    regs[wr_idx]     <= byte_merge(regs[wr_idx], wr_data, wr_strb);
                    wr_pulse[wr_idx] <= 1'b1;
                end
            end else if (bvalid && S_AXI_BREADY) begin
                bvalid <= 1'b0;
            end
        end
    end

    // Read capture sees the pre-write register value on a same-edge write
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= OKAY;
        end else if (ar_hs) begin
            rvalid <= 1'b1;
            rdata  <= rd_oor ? '0 : regs[rd_idx];
            rresp  <= rd_oor ? SLVERR : OKAY;
        end else if (rvalid && S_AXI_RREADY) begin
            rvalid <= 1'b0;
        end
    end

    assign S_AXI_BVALID = bvalid;
    assign S_AXI_BRESP  = bresp;
    assign S_AXI_RVALID = rvalid;
    assign S_AXI_RDATA  = rdata;
    assign S_AXI_RRESP  = rresp;
    assign WR_PULSE     = wr_pulse;
    assign REG_OUT      = {regs[3], regs[2], regs[1], regs[0]};

    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, wr_addr, S_AXI_ARADDR};

endmodule

// File: tb/tb_matrix_axil_regs.sv
// Scoreboard bench for matrix_axil_regs: B/R responses are queued when driven
// and checked when the handshake occurs.
module tb_matrix_axil_regs;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic         aclk = 1'b0;
    logic         areset = 1'b1;
    logic [5:0]   awaddr = '0;
    logic [2:0]   awprot = '0;
    logic         awvalid = 1'b0;
    logic         awready;
    logic [31:0]  wdata = '0;
    logic [3:0]   wstrb = '0;
    logic         wvalid = 1'b0;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready = 1'b1;
    logic [5:0]   araddr = '0;
    logic [2:0]   arprot = '0;
    logic         arvalid = 1'b0;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready = 1'b1;
    logic [127:0] reg_out;
    logic [3:0]   wr_pulse;

    int checks = 0;
    int failures = 0;

    logic [1:0]  b_exp_q [$];
    logic [33:0] r_exp_q [$];
    logic [31:0] model [4];
    logic [1:0]  mon_b;
    logic [33:0] mon_r;

    matrix_axil_regs dut (
        .ACLK(aclk), .ARESET(areset),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .REG_OUT(reg_out), .WR_PULSE(wr_pulse)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic is_oor(input logic [5:0] a);
`ifdef MATRIX_REGS_SLVERR_EN
        return |a[5:4];
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [127:0] model_out();
        return {model[3], model[2], model[1], model[0]};
    endfunction

    task automatic model_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
        if (!is_oor(a)) begin
            for (int k = 0; k < 4; k++) begin
                if (s[k]) model[a[3:2]][8*k +: 8] = d[8*k +: 8];
            end
        end
    endtask

    // Response monitor: pop the expectation on each B/R handshake
    always @(negedge aclk) begin
        if (!areset) begin
            if (bvalid && bready) begin
                if (b_exp_q.size() == 0) begin
                    check("b_unexpected", 1, 0);
                end else begin
                    mon_b = b_exp_q.pop_front();
                    check("bresp", bresp, mon_b);
                end
            end
            if (rvalid && rready) begin
                if (r_exp_q.size() == 0) begin
                    check("r_unexpected", 1, 0);
                end else begin
                    mon_r = r_exp_q.pop_front();
                    check("rdata", rdata, mon_r[31:0]);
                    check("rresp", rresp, mon_r[33:32]);
                end
            end
        end
    end

    task automatic drive_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
        bit aw_done = 0;
        bit w_done = 0;
        int n = 0;
        @(posedge aclk); #1;
        awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
        while (!(aw_done && w_done) && n < 40) begin
            @(negedge aclk);
            if (awvalid && awready) aw_done = 1;
            if (wvalid && wready) w_done = 1;
            @(posedge aclk); #1;
            if (aw_done) awvalid = 1'b0;
            if (w_done) wvalid = 1'b0;
            n++;
        end
        if (!(aw_done && w_done)) begin
            check("wr_handshake_timeout", 0, 1);
            awvalid = 1'b0;
            wvalid = 1'b0;
        end
    endtask

    task automatic drive_read(input logic [5:0] a);
        bit done = 0;
        int n = 0;
        @(posedge aclk); #1;
        araddr = a; arvalid = 1'b1;
        while (!done && n < 40) begin
            @(negedge aclk);
            if (arready) done = 1;
            @(posedge aclk); #1;
            if (done) arvalid = 1'b0;
            n++;
        end
        if (!done) begin
            check("rd_handshake_timeout", 0, 1);
            arvalid = 1'b0;
        end
    endtask

    task automatic wait_b();
        int n = 0;
        while (b_exp_q.size() != 0 && n < 40) begin
            @(posedge aclk); #1;
            n++;
        end
        if (b_exp_q.size() != 0) begin
            check("b_timeout", b_exp_q.size(), 0);
            b_exp_q.delete();
        end
    endtask

    task automatic wait_r();
        int n = 0;
        while (r_exp_q.size() != 0 && n < 40) begin
            @(posedge aclk); #1;
            n++;
        end
        if (r_exp_q.size() != 0) begin
            check("r_timeout", r_exp_q.size(), 0);
            r_exp_q.delete();
        end
    endtask

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
        b_exp_q.push_back(is_oor(a) ? SLVERR : OKAY);
        drive_write(a, d, s);
        model_write(a, d, s);
        wait_b();
    endtask

    task automatic axi_read(input logic [5:0] a);
        r_exp_q.push_back(is_oor(a) ? {SLVERR, 32'h0} : {OKAY, model[a[3:2]]});
        drive_read(a);
        wait_r();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) model[i] = '0;

        // reset state
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_awready", awready, 0);
        check("rst_reg_out", reg_out, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_wr_pulse", wr_pulse, 0);
        @(posedge aclk); #1;
        areset = 1'b0;
        @(negedge aclk);
        check("idle_awready", awready, 1);
        check("idle_wready", wready, 1);
        check("idle_arready", arready, 1);

        // sequential writes then reads
        for (int i = 0; i < 4; i++) axi_write(6'(i * 4), 32'(i + 1), 4'hF);
        for (int i = 0; i < 4; i++) axi_read(6'(i * 4));
        check("seq_reg_out", reg_out, 128'h00000004_00000003_00000002_00000001);

        // W three cycles ahead of AW
        b_exp_q.push_back(OKAY);
        @(posedge aclk); #1;
        wdata = 32'hA5A5A5A5; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge aclk);
        check("wfirst_wready", wready, 1);
        @(posedge aclk); #1;
        wvalid = 1'b0;
        repeat (3) begin
            @(negedge aclk);
            check("wfirst_no_bvalid", bvalid, 0);
            check("wfirst_wready_held", wready, 0);
        end
        @(posedge aclk); #1;
        awaddr = 6'h4; awvalid = 1'b1;
        @(negedge aclk);
        check("wfirst_awready", awready, 1);
        @(posedge aclk); #1;
        awvalid = 1'b0;
        @(negedge aclk);
        check("wfirst_bvalid", bvalid, 1);
        check("wfirst_pulse", wr_pulse, 4'b0010);
        @(negedge aclk);
        check("wfirst_pulse_end", wr_pulse, 4'b0000);
        model_write(6'h4, 32'hA5A5A5A5, 4'hF);
        wait_b();
        check("wfirst_reg_out", reg_out, model_out());

        // byte strobes
        axi_write(6'h8, 32'hFFFFFFFF, 4'hF);
        axi_write(6'h8, 32'h00000000, 4'b0101);
        r_exp_q.push_back({OKAY, 32'hFF00FF00});
        drive_read(6'h8);
        wait_r();

        // BREADY held low: no new AW/W until the B handshake
        bready = 1'b0;
        b_exp_q.push_back(OKAY);
        drive_write(6'h0, 32'h12345678, 4'hF);
        model_write(6'h0, 32'h12345678, 4'hF);
        awaddr = 6'h4; awvalid = 1'b1;
        repeat (5) begin
            @(negedge aclk);
            check("bhold_bvalid", bvalid, 1);
            check("bhold_awready", awready, 0);
            check("bhold_wready", wready, 0);
        end
        @(posedge aclk); #1;
        bready = 1'b1;
        @(negedge aclk);
        check("bhold_awready_hs_cycle", awready, 0);
        @(negedge aclk);
        check("bhold_awready_after", awready, 1);
        @(posedge aclk); #1;
        awvalid = 1'b0;
        b_exp_q.push_back(OKAY);
        wdata = 32'h00000009; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge aclk);
        check("bhold_wready_second", wready, 1);
        @(posedge aclk); #1;
        wvalid = 1'b0;
        model_write(6'h4, 32'h00000009, 4'hF);
        wait_b();
        check("bhold_reg_out", reg_out, model_out());

        // same-edge write and read of reg3
        axi_write(6'hC, 32'h11, 4'hF);
        r_exp_q.push_back({OKAY, model[3]});
        b_exp_q.push_back(OKAY);
        fork
            drive_write(6'hC, 32'h55, 4'hF);
            drive_read(6'hC);
        join
        model_write(6'hC, 32'h55, 4'hF);
        wait_b();
        wait_r();
        axi_read(6'hC);

        // upper address bits
        axi_write(6'h10, 32'h99, 4'hF);
        check("oor_reg_out", reg_out, model_out());
        axi_read(6'h10);

        // reset with an address held and a read response pending
        @(posedge aclk); #1;
        awaddr = 6'h4; awvalid = 1'b1;
        @(negedge aclk);
        check("rst_aw_accept", awready, 1);
        @(posedge aclk); #1;
        awvalid = 1'b0;
        rready = 1'b0;
        araddr = 6'h0; arvalid = 1'b1;
        @(posedge aclk); #1;
        arvalid = 1'b0;
        @(negedge aclk);
        check("pre_rst_rvalid", rvalid, 1);
        check("pre_rst_rdata", rdata, model[0]);
        @(posedge aclk); #1;
        areset = 1'b1;
        @(posedge aclk); #1;
        areset = 1'b0;
        rready = 1'b1;
        for (int i = 0; i < 4; i++) model[i] = '0;
        @(negedge aclk);
        check("mid_rst_reg_out", reg_out, 0);
        check("mid_rst_rvalid", rvalid, 0);
        check("mid_rst_rdata", rdata, 0);
        check("mid_rst_bvalid", bvalid, 0);
        check("mid_rst_wr_pulse", wr_pulse, 0);
        @(posedge aclk); #1;
        wdata = 32'hCAFE0001; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge aclk);
        check("post_rst_wready", wready, 1);
        @(posedge aclk); #1;
        wvalid = 1'b0;
        repeat (5) begin
            @(negedge aclk);
            check("post_rst_no_bvalid", bvalid, 0);
        end
        b_exp_q.push_back(OKAY);
        @(posedge aclk); #1;
        awaddr = 6'h8; awvalid = 1'b1;
        @(posedge aclk); #1;
        awvalid = 1'b0;
        model_write(6'h8, 32'hCAFE0001, 4'hF);
        wait_b();
        check("post_rst_reg_out", reg_out, model_out());

        repeat (3) @(posedge aclk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
